ads7883_emu: RTL

ADS7883_EMU -- requirements
Module: ads7883_emu

---
 rtl/ads7883_emu.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/ads7883_emu.sv
// ADS7883 serial ADC emulator: serves a 12-bit sample as a 16-clock SPI frame.
// SCLK and nCS are asynchronous to clk. Both are double-flopped and then
// edge-detected. Every output is registered.
module ads7883_emu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ads7883_sclk,
  input  logic        ads7883_ncs,
  input  logic [11:0] sample_data,
  input  logic        sample_valid,
  output logic        ads7883_sdo,
  output logic        sdo_oe,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

  // Frame layout, MSB first: two leading zeros, D11..D0, then two trailing zeros.
  function automatic logic [15:0] frame_word(input logic [11:0] data);
    return {2'b00, data, 2'b00};
  endfunction

  logic        ncs_meta_r, ncs_sync_r, ncs_prev_r;
  logic        sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic [1:0]  settle_r;
  logic        armed_r;
  logic [11:0] hold_r;
  state_t      state_r, state_nx_s;
  logic [4:0]  bit_cnt_r, cnt_nx_s;
  logic [14:0] shift_r, shift_nx_s;
  logic [15:0] load_word_s;
  logic        sdo_r, sdo_nx_s;
  logic        sdo_oe_r, oe_nx_s;
  logic        done_r, done_nx_s;
  logic        abort_r, abort_nx_s;
  logic        busy_r;
  logic        ncs_fall_s, ncs_rise_s, sclk_fall_s;

  // Two-flop synchronizers plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_meta_r  <= 1'b1;
      ncs_sync_r  <= 1'b1;
      ncs_prev_r  <= 1'b1;
      sclk_meta_r <= 1'b1;
      sclk_sync_r <= 1'b1;
      sclk_prev_r <= 1'b1;
    end else begin
      ncs_meta_r  <= ads7883_ncs;
      ncs_sync_r  <= ncs_meta_r;
      ncs_prev_r  <= ncs_sync_r;
      sclk_meta_r <= ads7883_sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
    end
  end

  // Arm frame starts only after nCS has been seen high through the synchronizer.
  // This keeps a pin held low across reset from posing as a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_r <= 2'd0;
      armed_r  <= 1'b0;
    end else begin
      if (settle_r != 2'd3) begin
        settle_r <= settle_r + 2'd1;
      end else begin
        settle_r <= settle_r;
      end
      if ((settle_r == 2'd3) && ncs_sync_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign ncs_fall_s  = armed_r & ncs_prev_r & ~ncs_sync_r;
  assign ncs_rise_s  = ~ncs_prev_r & ncs_sync_r;
  assign sclk_fall_s = sclk_prev_r & ~sclk_sync_r;
  assign load_word_s = frame_word(sample_valid ? sample_data : hold_r);

  // Holding register: a sample_valid strobe always captures, in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= 12'h000;
    end else if (sample_valid) begin
      hold_r <= sample_data;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = bit_cnt_r;
    shift_nx_s = shift_r;
    sdo_nx_s   = sdo_r;
    oe_nx_s    = sdo_oe_r;
    done_nx_s  = 1'b0;
    abort_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sdo_nx_s = 1'b1;
        oe_nx_s  = 1'b0;
        if (ncs_fall_s) begin
          state_nx_s = ST_SHIFT;
          cnt_nx_s   = 5'd0;
          shift_nx_s = load_word_s[14:0];
          sdo_nx_s   = load_word_s[15];
          oe_nx_s    = 1'b1;
        end else begin
          cnt_nx_s = 5'd0;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise_s) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 5'd0;
          shift_nx_s = 15'd0;
          sdo_nx_s   = 1'b1;
          oe_nx_s    = 1'b0;
          abort_nx_s = 1'b1;
        end else if (sclk_fall_s) begin
          if (bit_cnt_r == 5'd15) begin
            state_nx_s = ST_TAIL;
            cnt_nx_s   = 5'd16;
            shift_nx_s = 15'd0;
            sdo_nx_s   = 1'b0;
          end else begin
            cnt_nx_s   = bit_cnt_r + 5'd1;
            sdo_nx_s   = shift_r[14];
            shift_nx_s = {shift_r[13:0], 1'b0};
          end
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_TAIL: begin
        sdo_nx_s = 1'b0;
        if (ncs_rise_s) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 5'd0;
          sdo_nx_s   = 1'b1;
          oe_nx_s    = 1'b0;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_TAIL;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 5'd0;
        shift_nx_s = 15'd0;
        sdo_nx_s   = 1'b1;
        oe_nx_s    = 1'b0;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 5'd0;
      shift_r   <= 15'd0;
      sdo_r     <= 1'b1;
      sdo_oe_r  <= 1'b0;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      bit_cnt_r <= cnt_nx_s;
      shift_r   <= shift_nx_s;
      sdo_r     <= sdo_nx_s;
      sdo_oe_r  <= oe_nx_s;
      done_r    <= done_nx_s;
      abort_r   <= abort_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
    end
  end

  assign ads7883_sdo = sdo_r;
  assign sdo_oe      = sdo_oe_r;
  assign frame_done  = done_r;
  assign frame_abort = abort_r;
  assign busy        = busy_r;

endmodule
